lisnoc_packet_arbiter: RTL and testbench
========================================

// Module: lisnoc_packet_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one output link between N packet buffers.
//  Each requester is a packet buffer whose valid means "complete packet stored".
//  Grant is locked from the first flit to the LAST/SINGLE flit; the packet size is checked against the flit count.
//  Sits between the per-port packet buffers and the link/router output.
// PARAMETERS
//  data_width  32   payload bits; flit_width = data_width+2 (type in [flit_width-1:flit_width-2])
//  ports       4    number of requesters N, >=2
//  fifo_depth  256  requester buffer depth; size_width = $clog2(fifo_depth+1)
// PORTS
//  clk        in   1               clock; all state on rising edge
//  rst_n      in   1               asynchronous, active-low reset
//  in_flit    in   N*flit_width    requester flits, port i at [i*flit_width +: flit_width]
//  in_valid   in   N               requester i holds a complete packet / flit valid
//  in_size    in   N*size_width    flits in head packet of requester i
//  in_ready   out  N               pop strobe to requester i
//  out_flit   out  flit_width      granted flit
//  out_valid  out  1               out flit valid
//  out_ready  in   1               downstream accepts
//  out_size   out  size_width      size of packet in flight, captured at grant
//  out_grant  out  N               one-hot current grant, 0 when idle
//  err_size   out  1               sticky size-mismatch flag
//  err_clr    in   1               synchronous clear of err_size
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, rr_ptr=0, out_grant=0, out_size=0, remaining=0, err_size=0.
//  While rst_n=0: in_ready=0, out_valid=0.
//  FSM IDLE:
//   - If |in_valid: pick the first set bit searching rr_ptr, rr_ptr+1, ... wrapping mod N.
//   - Register the one-hot grant, out_size and remaining from in_size[g]; go XFER.
//   - No flit moves in IDLE (one bubble cycle per packet). in_ready=0, out_valid=0.
//  FSM XFER:
//   - Combinational path: out_flit=in_flit[g]; out_valid=in_valid[g].
//   - in_ready[g]=out_ready; in_ready of all other ports = 0.
//   - A flit is accepted when out_valid&out_ready. remaining decrements by 1 per accepted flit (saturates at 0).
//   - Accepted flit of type LAST or SINGLE: go IDLE next cycle, rr_ptr=(g+1) mod N, out_grant=0, out_size=0.
//   - in_valid[g] dropping mid-packet: out_valid=0, grant held, no other port served (no interleaving).
//  Size check, each sets err_size:
//   - in_size[g]==0 at grant.
//   - LAST/SINGLE accepted with remaining!=1.
//   - Non-last flit accepted with remaining==1.
//  On error the transfer continues to the true last flit; no abort, no flit drop.
//  err_size: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
//  Flit type PAYLOAD or HEADER (not LAST/SINGLE) keeps the grant.
//  Latency: in_valid rise -> first out_valid 2 cycles (IDLE edge + XFER); flits then combinational.
//  Max throughput: size/(size+1) flits per cycle per packet.
//  Simultaneous requests: the port nearest rr_ptr wins; all others wait, in_ready=0.
//  Port re-requesting right after its own packet: it is lowest priority for the next pick.
// STRUCTURE
//  Flit type encodings come from lisnoc_def.vh (FLIT_TYPE_PAYLOAD/HEADER/LAST/SINGLE); no new typedefs.
//  Sub-module lisnoc_rr_arbiter: combinational (req[N], ptr) -> one-hot gnt; reusable elsewhere.
//  Top holds FSM, grant/size/remaining registers, rr_ptr, error flag, output mux.
// TESTING
//  1. Single packet on port 0: size 3, HEADER,PAYLOAD,LAST, out_ready=1.
//     -> out_grant=0001 on cycle 1; flits on cycles 1-3; back to IDLE; rr_ptr=1; err_size=0.
//  2. All ports valid, SINGLE flits, 8 packets.
//     -> grant order 0,1,2,3,0,1,2,3; one bubble between packets.
//  3. Port 1 sends a size-4 packet; out_ready toggles 1010...
//     -> every flit seen exactly once, in order; in_ready[1] mirrors out_ready; ports 0/2/3 in_ready=0.
//  4. in_size=2 but 3 flits with LAST on the 3rd -> err_size=1 on the 2nd flit accept; all 3 flits forwarded.
//     Then err_clr=1 -> err_size=0 next cycle.
//  5. rst_n asserted in XFER mid-packet -> out_valid, in_ready, out_grant immediately 0.
//     After release, IDLE with rr_ptr=0: port 0 wins over port 2.
//  6. in_valid[g] drops for 3 cycles mid-packet while port 3 valid -> out_valid=0, grant held.
//     Port 3 served only after g's LAST flit.

Source files
------------

// File: rtl/lisnoc_packet_arbiter_pkg.sv
// Shared definitions for the packet arbiter slice.
//   - flit type encodings (same values as lisnoc_def.vh)
//   - arbiter FSM state type
//   - helper that classifies a flit type as packet-terminating
package lisnoc_packet_arbiter_pkg;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    function automatic logic is_last_type(input logic [1:0] flit_type);
        return (flit_type == FLIT_TYPE_LAST) || (flit_type == FLIT_TYPE_SINGLE);
    endfunction

endpackage

// File: rtl/lisnoc_rr_arbiter.sv
// Combinational round-robin pick.
//   i_req  [ports]  request vector
//   i_ptr          highest-priority index; search runs ptr, ptr+1, ... mod ports
//   o_gnt  [ports]  one-hot grant of the first requester found, 0 if none
module lisnoc_rr_arbiter #(
    parameter  int ports = 4,
    localparam int PW    = $clog2(ports)
) (
    input  logic [ports-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [ports-1:0] o_gnt
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < ports; k++) begin
            w_idx = (int'(i_ptr) + k) % ports;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_packet_arbiter.sv
// Packet-granular round-robin arbiter: N packet buffers share one output link.
// The grant is locked from the first flit of a packet until its LAST/SINGLE
// flit is accepted, and the flit count is checked against the advertised size.
//   clk, rst_n           clock, async active-low reset
//   in_flit/valid/size   per-requester head flit, packet-present, packet size
//   in_ready             per-requester pop strobe
//   out_flit/valid       granted flit towards the link
//   out_ready            link accepts
//   out_size, out_grant  size and one-hot owner of the packet in flight
//   err_size, err_clr    sticky size-mismatch flag and its synchronous clear
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no packet in flight; pick next requester, register grant/size
// ST_XFER | forward flits of granted port until LAST/SINGLE is accepted
module lisnoc_packet_arbiter
    import lisnoc_packet_arbiter_pkg::*;
#(
    parameter  int data_width = 32,
    parameter  int ports      = 4,
    parameter  int fifo_depth = 256,
    localparam int flit_width = data_width + 2,
    localparam int size_width = $clog2(fifo_depth + 1),
    localparam int PW         = $clog2(ports)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ports*flit_width-1:0] in_flit,
    input  logic [ports-1:0]            in_valid,
    input  logic [ports*size_width-1:0] in_size,
    output logic [ports-1:0]            in_ready,
    output logic [flit_width-1:0]       out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [size_width-1:0]       out_size,
    output logic [ports-1:0]            out_grant,
    output logic                        err_size,
    input  logic                        err_clr
);

    arb_state_t            r_state, w_state_nxt;
    logic [ports-1:0]      r_grant, w_grant_nxt, w_rr_gnt;
    logic [PW-1:0]         r_rr_ptr, w_rr_ptr_nxt, w_gidx, w_new_idx;
    logic [size_width-1:0] r_size, w_size_nxt, r_remaining, w_remaining_nxt, w_new_size;
    logic                  r_err, w_err_set;
    logic [flit_width-1:0] w_flit;
    logic                  w_valid, w_accept, w_last;

    lisnoc_rr_arbiter #(.ports(ports)) u_rr (
        .i_req (in_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt)
    );

    // one-hot to index for the current grant and the fresh pick
    always_comb begin
        w_gidx    = '0;
        w_new_idx = '0;
        for (int i = 0; i < ports; i++) begin
            if (r_grant[i])  w_gidx    = PW'(i);
            if (w_rr_gnt[i]) w_new_idx = PW'(i);
        end
    end

    assign w_new_size = in_size[int'(w_new_idx)*size_width +: size_width];
    assign w_flit     = in_flit[int'(w_gidx)*flit_width +: flit_width];
    assign w_valid    = (r_state == ST_XFER) && in_valid[w_gidx];
    assign w_accept   = w_valid && out_ready;
    assign w_last     = is_last_type(w_flit[flit_width-1 -: 2]);

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_size_nxt      = r_size;
        w_remaining_nxt = r_remaining;
        w_err_set       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|in_valid) begin
                    w_grant_nxt     = w_rr_gnt;
                    w_size_nxt      = w_new_size;
                    w_remaining_nxt = w_new_size;
                    w_err_set       = (w_new_size == '0);
                    w_state_nxt     = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_accept) begin
                    if (r_remaining != '0) w_remaining_nxt = r_remaining - 1'b1;
                    if (w_last) begin
                        w_err_set    = (r_remaining != size_width'(1));
                        w_state_nxt  = ST_IDLE;
                        w_grant_nxt  = '0;
                        w_size_nxt   = '0;
                        // the port just served drops to lowest priority
                        w_rr_ptr_nxt = (w_gidx == PW'(ports - 1)) ? '0 : w_gidx + 1'b1;
                    end else begin
                        w_err_set = (r_remaining == size_width'(1));
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_size      <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_size      <= w_size_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // a new mismatch wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
        else if (err_clr)   r_err <= 1'b0;
    end

    assign in_ready  = (r_state == ST_XFER) ? (r_grant & {ports{out_ready}}) : '0;
    assign out_flit  = w_flit;
    assign out_valid = w_valid;
    assign out_size  = r_size;
    assign out_grant = r_grant;
    assign err_size  = r_err;

endmodule

// File: tb/tb_lisnoc_packet_arbiter.sv
// Directed bench for lisnoc_packet_arbiter: per-port packet sources that pop
// on in_ready, an output log of accepted flits, and hand-computed expectations.
module tb_lisnoc_packet_arbiter;
    import lisnoc_packet_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int FW = DW + 2;
    localparam int SW = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*FW-1:0] in_flit;
    logic [N-1:0]    in_valid;
    logic [N*SW-1:0] in_size;
    logic [N-1:0]    in_ready;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_size;
    logic [N-1:0]    out_grant;
    logic            err_size;
    logic            err_clr;

    lisnoc_packet_arbiter #(.data_width(DW), .ports(N), .fifo_depth(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_size   (in_size),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_size  (out_size),
        .out_grant (out_grant),
        .err_size  (err_size),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] flit;
        logic [N-1:0]  gnt;
        int            cyc;
    } ent_t;

    logic [FW-1:0] src_mem [N][16];
    int            src_len [N];
    int            src_ptr [N];
    bit            src_hold[N];
    logic [SW-1:0] src_size[N];
    ent_t          log_q[$];
    logic [N-1:0]  rdy_s, vld_s;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]           = (src_ptr[i] < src_len[i]) && !src_hold[i];
            in_flit[i*FW +: FW]   = (src_ptr[i] < src_len[i]) ? src_mem[i][src_ptr[i]] : '0;
            in_size[i*SW +: SW]   = src_size[i];
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 0;
            src_ptr[i]  = 0;
            src_hold[i] = 1'b0;
            src_size[i] = '0;
        end
        log_q.delete();
    endtask

    task automatic load(input int p, input logic [1:0] t, input logic [31:0] d);
        src_mem[p][src_len[p]] = {t, d};
        src_len[p]++;
    endtask

    // sample before the edge, pop accepted flits just after it
    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        rdy_s = in_ready;
        vld_s = in_valid;
        if (out_valid && out_ready) log_q.push_back('{out_flit, out_grant, cyc});
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++)
            if (rdy_s[i] && vld_s[i]) src_ptr[i]++;
        drive();
        #1;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("log_count", 64'(log_q.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        in_flit   = '0;
        in_valid  = '0;
        in_size   = '0;
        clear_srcs();

        // ---- 1: single packet on port 0, reset values ----
        load(0, FLIT_TYPE_HEADER,  32'h100);
        load(0, FLIT_TYPE_PAYLOAD, 32'h101);
        load(0, FLIT_TYPE_LAST,    32'h102);
        src_size[0] = 9'd3;
        drive();
        #1;
        chk("rst_grant", 64'(out_grant), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_ready", 64'(in_ready),  64'h0);
        chk("rst_size",  64'(out_size),  64'h0);
        chk("rst_err",   64'(err_size),  64'h0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("idle_valid", 64'(out_valid), 64'h0);
        chk("idle_ready", 64'(in_ready),  64'h0);
        tick();
        chk("t1_grant", 64'(out_grant), 64'h1);
        chk("t1_size",  64'(out_size),  64'd3);
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_flit0", 64'(out_flit),  64'({FLIT_TYPE_HEADER, 32'h100}));
        chk("t1_ready", 64'(in_ready),  64'h1);
        tick();
        chk("t1_flit1", 64'(out_flit),  64'({FLIT_TYPE_PAYLOAD, 32'h101}));
        tick();
        chk("t1_flit2", 64'(out_flit),  64'({FLIT_TYPE_LAST, 32'h102}));
        tick();
        chk("t1_end_grant", 64'(out_grant), 64'h0);
        chk("t1_end_size",  64'(out_size),  64'h0);
        chk("t1_end_valid", 64'(out_valid), 64'h0);
        chk("t1_end_err",   64'(err_size),  64'h0);
        chk("t1_count",     64'(log_q.size()), 64'd3);
        chk("t1_back2back", 64'(log_q[2].cyc - log_q[0].cyc), 64'd2);

        // rr_ptr is now 1: port 2 beats port 0, then port 0
        clear_srcs();
        load(0, FLIT_TYPE_SINGLE, 32'h200); src_size[0] = 9'd1;
        load(2, FLIT_TYPE_SINGLE, 32'h220); src_size[2] = 9'd1;
        drive();
        wait_log(2, 10);
        chk("t1_rr_first",  64'(log_q[0].gnt), 64'b0100);
        chk("t1_rr_second", 64'(log_q[1].gnt), 64'b0001);

        // ---- 2: all ports, SINGLE flits, 8 packets ----
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        clear_srcs();
        for (int p = 0; p < N; p++) begin
            load(p, FLIT_TYPE_SINGLE, 32'(p*16));
            load(p, FLIT_TYPE_SINGLE, 32'(p*16 + 1));
            src_size[p] = 9'd1;
        end
        drive();
        wait_log(8, 40);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_gnt%0d", i),  64'(log_q[i].gnt), 64'(4'b0001 << (i % 4)));
            chk($sformatf("t2_data%0d", i), 64'(log_q[i].flit), 64'({FLIT_TYPE_SINGLE, 32'((i % 4)*16 + i/4)}));
            if (i > 0)
                chk($sformatf("t2_gap%0d", i), 64'(log_q[i].cyc - log_q[i-1].cyc), 64'd2);
        end

        // ---- 3: port 1 size 4 with out_ready toggling ----
        clear_srcs();
        load(1, FLIT_TYPE_HEADER,  32'h30);
        load(1, FLIT_TYPE_PAYLOAD, 32'h31);
        load(1, FLIT_TYPE_PAYLOAD, 32'h32);
        load(1, FLIT_TYPE_LAST,    32'h33);
        src_size[1] = 9'd4;
        drive();
        tick();
        load(0, FLIT_TYPE_SINGLE, 32'h300); src_size[0] = 9'd1;
        load(2, FLIT_TYPE_SINGLE, 32'h320); src_size[2] = 9'd1;
        load(3, FLIT_TYPE_SINGLE, 32'h330); src_size[3] = 9'd1;
        drive();
        begin
            int k;
            k = 0;
            while (log_q.size() < 4 && k < 20) begin
                out_ready = (k % 2 == 0);
                #1;
                chk("t3_ready", 64'(in_ready), 64'(out_ready ? 4'b0010 : 4'b0000));
                chk("t3_grant", 64'(out_grant), 64'b0010);
                tick();
                k++;
            end
        end
        chk("t3_count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_data%0d", i), 64'(log_q[i].flit[31:0]), 64'(32'h30 + i));
            chk($sformatf("t3_own%0d", i),  64'(log_q[i].gnt), 64'b0010);
        end
        out_ready = 1'b1;
        wait_log(7, 20);
        chk("t3_next0", 64'(log_q[4].gnt), 64'b0100);
        chk("t3_next1", 64'(log_q[5].gnt), 64'b1000);
        chk("t3_next2", 64'(log_q[6].gnt), 64'b0001);

        // ---- 4: size 2 but 3 flits, then clear; zero size at grant ----
        clear_srcs();
        load(2, FLIT_TYPE_HEADER,  32'h400);
        load(2, FLIT_TYPE_PAYLOAD, 32'h401);
        load(2, FLIT_TYPE_LAST,    32'h402);
        src_size[2] = 9'd2;
        drive();
        tick();
        chk("t4_size",    64'(out_size), 64'd2);
        chk("t4_err_a",   64'(err_size), 64'h0);
        tick();
        chk("t4_err_b",   64'(err_size), 64'h0);
        tick();
        chk("t4_err_c",   64'(err_size), 64'h1);
        tick();
        chk("t4_err_d",   64'(err_size), 64'h1);
        chk("t4_count",   64'(log_q.size()), 64'd3);
        chk("t4_lastflit",64'(log_q[2].flit), 64'({FLIT_TYPE_LAST, 32'h402}));
        err_clr = 1'b1;
        tick();
        chk("t4_clr",     64'(err_size), 64'h0);
        err_clr = 1'b0;

        clear_srcs();
        load(3, FLIT_TYPE_SINGLE, 32'h430);
        src_size[3] = 9'd0;
        err_clr = 1'b1;
        drive();
        tick();
        chk("t4_zero_set", 64'(err_size), 64'h1);
        chk("t4_zero_gnt", 64'(out_grant), 64'b1000);
        tick();
        chk("t4_zero_hold", 64'(err_size), 64'h1);
        tick();
        chk("t4_zero_clr", 64'(err_size), 64'h0);
        err_clr = 1'b0;

        // ---- 5: reset mid-packet ----
        clear_srcs();
        load(1, FLIT_TYPE_HEADER,  32'h500);
        load(1, FLIT_TYPE_PAYLOAD, 32'h501);
        load(1, FLIT_TYPE_LAST,    32'h502);
        src_size[1] = 9'd3;
        drive();
        tick();
        chk("t5_grant", 64'(out_grant), 64'b0010);
        tick();
        chk("t5_mid_valid", 64'(out_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'h0);
        chk("t5_rst_ready", 64'(in_ready),  64'h0);
        chk("t5_rst_grant", 64'(out_grant), 64'h0);
        clear_srcs();
        load(0, FLIT_TYPE_SINGLE, 32'h600); src_size[0] = 9'd1;
        load(2, FLIT_TYPE_SINGLE, 32'h620); src_size[2] = 9'd1;
        drive();
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        chk("t5_after_grant", 64'(out_grant), 64'b0001);
        wait_log(2, 10);
        chk("t5_second", 64'(log_q[1].gnt), 64'b0100);

        // ---- 6: granted port stalls for 3 cycles while port 3 waits ----
        clear_srcs();
        load(0, FLIT_TYPE_HEADER,  32'h700);
        load(0, FLIT_TYPE_PAYLOAD, 32'h701);
        load(0, FLIT_TYPE_LAST,    32'h702);
        src_size[0] = 9'd3;
        drive();
        tick();
        chk("t6_grant", 64'(out_grant), 64'b0001);
        tick();
        src_hold[0] = 1'b1;
        load(3, FLIT_TYPE_SINGLE, 32'h730); src_size[3] = 9'd1;
        drive();
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t6_stall_valid%0d", c), 64'(out_valid), 64'h0);
            chk($sformatf("t6_stall_grant%0d", c), 64'(out_grant), 64'b0001);
            chk($sformatf("t6_stall_rdy3_%0d", c), 64'(in_ready[3]), 64'h0);
            tick();
        end
        src_hold[0] = 1'b0;
        drive();
        wait_log(4, 20);
        chk("t6_gap",   64'(log_q[1].cyc - log_q[0].cyc), 64'd4);
        chk("t6_flit1", 64'(log_q[1].flit), 64'({FLIT_TYPE_PAYLOAD, 32'h701}));
        chk("t6_flit2", 64'(log_q[2].flit), 64'({FLIT_TYPE_LAST, 32'h702}));
        chk("t6_p3gnt", 64'(log_q[3].gnt),  64'b1000);
        chk("t6_p3flit",64'(log_q[3].flit), 64'({FLIT_TYPE_SINGLE, 32'h730}));
        chk("t6_err",   64'(err_size), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
